// File: rtl/aes_out_fifo_axis_tx_if.sv
// AXI-Stream channel carrying serialized AES result words.
//   tvalid/tdata/tstrb/tlast : driven by the master (the transmitter)
//   tready                   : driven by the slave (downstream sink)
interface aes_out_fifo_axis_tx_if #(
  parameter int WORD_W = 32
);
  logic              tvalid;
  logic [WORD_W-1:0] tdata;
  logic [WORD_W/8-1:0] tstrb;
  logic              tlast;
  logic              tready;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/aes_out_fifo_axis_tx.sv
// aes_out_fifo_axis_tx
//   Buffers 128-bit AES result blocks in block RAM and, on a start pulse,
//   serializes every stored block as WORD_W-bit AXI-Stream words (MSW first),
//   with tlast on the final word of the final block.
// Ports
//   clk, reset   : clock (posedge) and synchronous active-high reset
//   blk_w_e      : block write strobe (accepted only in IDLE and not full)
//   blk_i_data   : block to store
//   blk_full     : blk_cnt == DEPTH
//   blk_cnt      : blocks currently stored
//   start        : pulse, transmit all stored blocks (ignored while busy)
//   busy         : transmitter not idle
//   done         : one-cycle pulse after the final handshake / empty start
//   m_axis       : AXI-Stream master (aes_out_fifo_axis_tx_if.master)
// Build option
//   AES_OUT_PREFETCH_EN : prefetch the next block into a holding register
//   while the current one is shifting out, giving a gapless stream.
module aes_out_fifo_axis_tx #(
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512,
  parameter int BLK_W      = 128,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blk_w_e,
  input  logic [BLK_W-1:0]      blk_i_data,
  output logic                  blk_full,
  output logic [ADDR_WIDTH:0]   blk_cnt,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  aes_out_fifo_axis_tx_if.master m_axis
);

  localparam int WPB  = BLK_W / WORD_W;
  localparam int WC_W = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_LATCH, S_SEND} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_addr;
  logic [ADDR_WIDTH:0]   cnt_nx;
  logic [WC_W-1:0]       word_cnt;
  logic [BLK_W-1:0]      shift_reg, sram_q;
  logic [BLK_W-1:0]      mem [0:DEPTH-1];
  logic                  wr_acc, rd_en, hs, last_word, last_blk;
`ifdef AES_OUT_PREFETCH_EN
  logic [BLK_W-1:0]      hold_reg;
  logic                  pf_pend;
`endif

  assign blk_full  = (blk_cnt == (ADDR_WIDTH+1)'(DEPTH));
  assign wr_acc    = blk_w_e && !blk_full && (state == S_IDLE);
  // start in the same cycle as an accepted write sees the updated count
  assign cnt_nx    = blk_cnt + (ADDR_WIDTH+1)'(wr_acc);
  assign hs        = m_axis.tvalid && m_axis.tready;
  assign last_word = (word_cnt == WC_W'(WPB-1));
  assign last_blk  = ({1'b0, rd_ptr} == blk_cnt - (ADDR_WIDTH+1)'(1));

  assign m_axis.tdata = shift_reg[BLK_W-1 -: WORD_W];
  assign m_axis.tstrb = '1;
  assign m_axis.tlast = m_axis.tvalid && last_word && last_blk;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && cnt_nx != '0) state_nx = S_RD;
      S_RD:    state_nx = S_LATCH;
      S_LATCH: state_nx = S_SEND;
      S_SEND: begin
        if (hs && last_word) begin
`ifdef AES_OUT_PREFETCH_EN
          state_nx = last_blk ? S_IDLE : S_SEND;
`else
          state_nx = last_blk ? S_IDLE : S_RD;
`endif
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs and RAM read control
  always_comb begin
    busy          = (state != S_IDLE);
    m_axis.tvalid = (state == S_SEND);
    rd_en         = (state == S_RD);
    rd_addr       = rd_ptr;
`ifdef AES_OUT_PREFETCH_EN
    // fetch the following block while word 0 of the current one is on the bus
    if (state == S_SEND && word_cnt == '0 && !last_blk) begin
      rd_en   = 1'b1;
      rd_addr = rd_ptr + ADDR_WIDTH'(1);
    end
`endif
  end

  // Block RAM, synchronous read
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= blk_i_data;
    if (rd_en)  sram_q <= mem[rd_addr];
  end

  // Pointers, counters and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      word_cnt  <= '0;
      shift_reg <= '0;
      done      <= 1'b0;
`ifdef AES_OUT_PREFETCH_EN
      hold_reg  <= '0;
      pf_pend   <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      blk_cnt <= cnt_nx;
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
`ifdef AES_OUT_PREFETCH_EN
      pf_pend <= rd_en && (state == S_SEND);
      if (pf_pend) hold_reg <= sram_q;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_ptr <= '0;
            if (cnt_nx == '0) done <= 1'b1;
          end
        end
        S_LATCH: begin
          shift_reg <= sram_q;
          word_cnt  <= '0;
        end
        S_SEND: begin
          if (hs) begin
            shift_reg <= shift_reg << WORD_W;
            word_cnt  <= word_cnt + WC_W'(1);
            if (last_word) begin
              word_cnt <= '0;
              rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
              if (last_blk) begin
                done    <= 1'b1;
                blk_cnt <= '0;
                wr_ptr  <= '0;
              end
`ifdef AES_OUT_PREFETCH_EN
              else begin
                shift_reg <= hold_reg;
              end
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
